// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front end for the core's data-side block RAM (word wide,
// same-cycle read). Turns byte-addressed byte/half/word requests into word
// accesses. Loads extract one lane and sign- or zero-extend it. Sub-word
// stores use a two-cycle read-modify-write. Misaligned requests and the
// reserved size are reported without touching memory.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (accept = valid & ready)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned          zero-extend sub-word loads
//   req_address           byte address (upper bits wrap modulo RAM size)
//   req_wdata             store data, right-aligned
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_misaligned       qualifies resp_valid: misaligned or reserved size
//   mem_*                 RAM read and write ports
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [ADDR_WIDTH-1:0]     req_address,
    input  logic [DATA_WIDTH-1:0]     req_wdata,

    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_misaligned,

    output logic                      mem_readEnable,
    output logic [MEM_ADDR_WIDTH-1:0] mem_readAddress,
    input  logic [DATA_WIDTH-1:0]     mem_readData,
    output logic                      mem_writeEnable,
    output logic [MEM_ADDR_WIDTH-1:0] mem_writeAddress,
    output logic [DATA_WIDTH-1:0]     mem_writeData
);

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } accessSize_t;

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    state_t state;
    state_t nextState;

    // Request decode
    logic [MEM_ADDR_WIDTH-1:0] wordAddress;
    logic [1:0]                lane;
    logic [4:0]                byteShift;
    logic [4:0]                halfShift;
    logic                      accept;
    logic                      isMisaligned;
    logic                      isSubWordStore;

    // Load extraction and store lane placement
    logic [7:0]                laneByte;
    logic [15:0]               laneHalf;
    logic [DATA_WIDTH-1:0]     loadData;
    logic [DATA_WIDTH-1:0]     storeMask;
    logic [DATA_WIDTH-1:0]     storeData;

    // Read-modify-write buffers, filled at the end of the read cycle
    logic [MEM_ADDR_WIDTH-1:0] rmwAddress;
    logic [DATA_WIDTH-1:0]     rmwOld;
    logic [DATA_WIDTH-1:0]     rmwMask;
    logic [DATA_WIDTH-1:0]     rmwData;

    // Byte-address bits above the RAM's reach are deliberately ignored.
    logic unusedAddressBits;
    assign unusedAddressBits = ^req_address[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

    assign wordAddress = req_address[MEM_ADDR_WIDTH+1:2];
    assign lane        = req_address[1:0];
    assign byteShift   = {lane, 3'b000};
    assign halfShift   = {req_address[1], 4'b0000};

    // Reset masks ready so nothing is accepted, and no enable fires, while
    // reset is held.
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        isMisaligned = 1'b0;
        case (req_size)
            SIZE_HALF: isMisaligned = req_address[0];
            SIZE_WORD: isMisaligned = (lane != 2'b00);
            SIZE_RSVD: isMisaligned = 1'b1;
            default:   isMisaligned = 1'b0;
        endcase
    end

    assign isSubWordStore = req_write && !isMisaligned && (req_size != SIZE_WORD);

    // Lane extraction straight off the same-cycle RAM read data.
    assign laneByte = 8'(mem_readData >> byteShift);
    assign laneHalf = 16'(mem_readData >> halfShift);

    always_comb begin
        loadData = '0;
        case (req_size)
            SIZE_BYTE: loadData = {{(DATA_WIDTH-8){~req_unsigned & laneByte[7]}}, laneByte};
            SIZE_HALF: loadData = {{(DATA_WIDTH-16){~req_unsigned & laneHalf[15]}}, laneHalf};
            default:   loadData = mem_readData;
        endcase
    end

    always_comb begin
        storeMask = '0;
        storeData = '0;
        if (req_size == SIZE_HALF) begin
            storeMask = DATA_WIDTH'(16'hFFFF) << halfShift;
            storeData = req_wdata << halfShift;
        end else begin
            storeMask = DATA_WIDTH'(8'hFF) << byteShift;
            storeData = req_wdata << byteShift;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (accept && isSubWordStore) nextState = RMW_WRITE;
            RMW_WRITE: nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // RAM port drive. In IDLE the ports follow the request combinationally
    // and fire only on an accepted, aligned request. In RMW_WRITE they come
    // from the latched buffers; reset gates the write off immediately.
    always_comb begin
        mem_readEnable   = 1'b0;
        mem_readAddress  = '0;
        mem_writeEnable  = 1'b0;
        mem_writeAddress = '0;
        mem_writeData    = '0;
        if (state == RMW_WRITE) begin
            mem_writeEnable  = !reset;
            mem_writeAddress = rmwAddress;
            mem_writeData    = (rmwOld & ~rmwMask) | (rmwData & rmwMask);
        end else if (accept && !isMisaligned) begin
            if (req_write && (req_size == SIZE_WORD)) begin
                mem_writeEnable  = 1'b1;
                mem_writeAddress = wordAddress;
                mem_writeData    = req_wdata;
            end else begin
                // Loads and the read half of a sub-word store.
                mem_readEnable  = 1'b1;
                mem_readAddress = wordAddress;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the RMW buffers are a handful of flops, not a RAM array,
            // so they are cleared with the rest of the state.
            state           <= IDLE;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            rmwAddress      <= '0;
            rmwOld          <= '0;
            rmwMask         <= '0;
            rmwData         <= '0;
        end else begin
            state      <= nextState;
            resp_valid <= 1'b0;
            if (state == RMW_WRITE) begin
                // The merged write commits at this edge; report completion.
                resp_valid      <= 1'b1;
                resp_rdata      <= '0;
                resp_misaligned <= 1'b0;
            end else if (accept) begin
                if (isMisaligned) begin
                    resp_valid      <= 1'b1;
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b1;
                end else if (!req_write) begin
                    resp_valid      <= 1'b1;
                    resp_rdata      <= loadData;
                    resp_misaligned <= 1'b0;
                end else if (req_size == SIZE_WORD) begin
                    resp_valid      <= 1'b1;
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b0;
                end else begin
                    rmwAddress <= wordAddress;
                    rmwOld     <= mem_readData;
                    rmwMask    <= storeMask;
                    rmwData    <= storeData;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. A behavioural same-cycle-read RAM is
// attached to the memory ports. Inputs change on the falling edge; registered
// outputs are checked at the falling edge and combinational RAM-port outputs
// 1 ns after the inputs change.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MAW = 8;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SR = 2'b11;

    logic           clock = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [1:0]     req_size;
    logic           req_unsigned;
    logic [AW-1:0]  req_address;
    logic [DW-1:0]  req_wdata;
    logic           resp_valid;
    logic [DW-1:0]  resp_rdata;
    logic           resp_misaligned;
    logic           mem_readEnable;
    logic [MAW-1:0] mem_readAddress;
    logic [DW-1:0]  mem_readData;
    logic           mem_writeEnable;
    logic [MAW-1:0] mem_writeAddress;
    logic [DW-1:0]  mem_writeData;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ram [0:(1<<MAW)-1];

    always #5 clock = ~clock;

    assign mem_readData = ram[mem_readAddress];

    always @(posedge clock) begin
        if (mem_writeEnable) ram[mem_writeAddress] <= mem_writeData;
    end

    mem_access_unit #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_readEnable  (mem_readEnable),
        .mem_readAddress (mem_readAddress),
        .mem_readData    (mem_readData),
        .mem_writeEnable (mem_writeEnable),
        .mem_writeAddress(mem_writeAddress),
        .mem_writeData   (mem_writeData)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic write, input logic [1:0] size, input logic uns,
                         input logic [31:0] address, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_write    = write;
        req_size     = size;
        req_unsigned = uns;
        req_address  = address;
        req_wdata    = wdata;
    endtask

    task automatic idleReq();
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SW;
        req_unsigned = 1'b0;
        req_address  = '0;
        req_wdata    = '0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < (1 << MAW); i++) ram[i] <= '0;

        // Reset: request presented, nothing may be accepted or enabled.
        drive(1'b0, SW, 1'b0, 32'h10, 32'h0);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_ren", mem_readEnable, 0);
        check("rst_wen", mem_writeEnable, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_mis", resp_misaligned, 0);

        @(negedge clock);
        reset = 1'b0;
        idleReq();
        ram[4] <= 32'h80FF7F01;

        // Load sizes and extension.
        @(negedge clock);
        drive(1'b0, SB, 1'b0, 32'h11, 32'h0);
        #1;
        check("lb_ren", mem_readEnable, 1);
        check("lb_raddr", mem_readAddress, 32'h4);
        check("lb_wen", mem_writeEnable, 0);
        check("lb_ready", req_ready, 1);

        @(negedge clock);
        check("lb11_valid", resp_valid, 1);
        check("lb11_rdata", resp_rdata, 32'h0000007F);
        check("lb11_mis", resp_misaligned, 0);
        drive(1'b0, SB, 1'b0, 32'h13, 32'h0);

        @(negedge clock);
        check("lb13_valid", resp_valid, 1);
        check("lb13_rdata", resp_rdata, 32'hFFFFFF80);
        drive(1'b0, SB, 1'b1, 32'h13, 32'h0);

        @(negedge clock);
        check("lbu13_rdata", resp_rdata, 32'h00000080);
        drive(1'b0, SH, 1'b0, 32'h12, 32'h0);

        @(negedge clock);
        check("lh12_rdata", resp_rdata, 32'hFFFF80FF);
        drive(1'b0, SW, 1'b1, 32'h10, 32'h0);

        @(negedge clock);
        check("lw10_valid", resp_valid, 1);
        check("lw10_rdata", resp_rdata, 32'h80FF7F01);
        idleReq();
        #1;
        check("idle_ren", mem_readEnable, 0);
        check("idle_wen", mem_writeEnable, 0);

        @(negedge clock);
        check("idle_valid", resp_valid, 0);
        check("hold_rdata", resp_rdata, 32'h80FF7F01);
        ram[4] <= 32'h11223344;

        // Sub-word byte store: read cycle then merged write.
        @(negedge clock);
        drive(1'b1, SB, 1'b0, 32'h12, 32'h123456AB);
        #1;
        check("sb_ren", mem_readEnable, 1);
        check("sb_raddr", mem_readAddress, 32'h4);
        check("sb_wen_rd", mem_writeEnable, 0);

        @(negedge clock);
        idleReq();
        #1;
        check("sb_rmw_ready", req_ready, 0);
        check("sb_rmw_wen", mem_writeEnable, 1);
        check("sb_rmw_waddr", mem_writeAddress, 32'h4);
        check("sb_rmw_wdata", mem_writeData, 32'h11AB3344);
        check("sb_rmw_ren", mem_readEnable, 0);
        check("sb_rmw_valid", resp_valid, 0);

        @(negedge clock);
        check("sb_valid", resp_valid, 1);
        check("sb_rdata", resp_rdata, 0);
        check("sb_ram", ram[4], 32'h11AB3344);
        check("sb_ready", req_ready, 1);
        drive(1'b1, SH, 1'b0, 32'h10, 32'h9999CDEF);

        // Halfword store; a load is held on the bus during RMW_WRITE.
        @(negedge clock);
        drive(1'b0, SW, 1'b0, 32'h10, 32'h0);
        #1;
        check("sh_rmw_ready", req_ready, 0);
        check("sh_rmw_ren", mem_readEnable, 0);
        check("sh_rmw_wdata", mem_writeData, 32'h11ABCDEF);

        @(negedge clock);
        check("sh_valid", resp_valid, 1);
        #1;
        check("hz_ren", mem_readEnable, 1);

        @(negedge clock);
        check("hz_valid", resp_valid, 1);
        check("hz_rdata", resp_rdata, 32'h11ABCDEF);
        drive(1'b1, SW, 1'b0, 32'h20, 32'hDEADBEEF);
        #1;
        check("sw_wen", mem_writeEnable, 1);
        check("sw_waddr", mem_writeAddress, 32'h8);
        check("sw_wdata", mem_writeData, 32'hDEADBEEF);
        check("sw_ren", mem_readEnable, 0);

        // Back-to-back store, word load, byte load.
        @(negedge clock);
        check("sw_valid", resp_valid, 1);
        check("sw_rdata", resp_rdata, 0);
        drive(1'b0, SW, 1'b0, 32'h20, 32'h0);

        @(negedge clock);
        check("b2b_lw_valid", resp_valid, 1);
        check("b2b_lw_rdata", resp_rdata, 32'hDEADBEEF);
        drive(1'b0, SB, 1'b0, 32'h23, 32'h0);

        @(negedge clock);
        check("b2b_lb_valid", resp_valid, 1);
        check("b2b_lb_rdata", resp_rdata, 32'hFFFFFFDE);
        drive(1'b0, SW, 1'b0, 32'h22, 32'h0);
        #1;
        check("mis_lw_ren", mem_readEnable, 0);
        check("mis_lw_wen", mem_writeEnable, 0);

        // Misaligned and reserved-size requests.
        @(negedge clock);
        check("mis_lw_valid", resp_valid, 1);
        check("mis_lw_flag", resp_misaligned, 1);
        check("mis_lw_rdata", resp_rdata, 0);
        drive(1'b1, SH, 1'b0, 32'h13, 32'h0000FFFF);
        #1;
        check("mis_sh_ren", mem_readEnable, 0);
        check("mis_sh_wen", mem_writeEnable, 0);

        @(negedge clock);
        check("mis_sh_valid", resp_valid, 1);
        check("mis_sh_flag", resp_misaligned, 1);
        drive(1'b0, SR, 1'b0, 32'h10, 32'h0);
        #1;
        check("mis_sz_ren", mem_readEnable, 0);
        check("mis_sz_wen", mem_writeEnable, 0);

        @(negedge clock);
        check("mis_sz_valid", resp_valid, 1);
        check("mis_sz_flag", resp_misaligned, 1);
        check("mis_sz_rdata", resp_rdata, 0);
        check("mis_ram4", ram[4], 32'h11ABCDEF);
        check("mis_ram8", ram[8], 32'hDEADBEEF);
        idleReq();

        @(negedge clock);
        check("mis_hold", resp_misaligned, 1);
        check("mis_idle_valid", resp_valid, 0);
        drive(1'b1, SB, 1'b0, 32'h08, 32'h00000055);

        // Reset during the RMW_WRITE cycle.
        @(negedge clock);
        idleReq();
        reset = 1'b1;
        #1;
        check("rrmw_wen", mem_writeEnable, 0);
        check("rrmw_ready", req_ready, 0);
        check("rrmw_valid", resp_valid, 0);

        @(negedge clock);
        reset = 1'b0;
        check("rrmw_ram2", ram[2], 0);
        check("rrmw_valid2", resp_valid, 0);
        check("rrmw_mis", resp_misaligned, 0);

        @(negedge clock);
        check("rrmw_ready2", req_ready, 1);
        check("rrmw_valid3", resp_valid, 0);
        drive(1'b1, SW, 1'b0, 32'h400, 32'h12345678);
        #1;
        check("wrap_wen", mem_writeEnable, 1);
        check("wrap_waddr", mem_writeAddress, 0);

        // Address wrap: byte address 0x400 lands on RAM word 0.
        @(negedge clock);
        check("wrap_valid", resp_valid, 1);
        check("wrap_ram0", ram[0], 32'h12345678);
        idleReq();

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
